// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops load the result on accept; multiply is an iterative shift-add.
module alu_mc #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = $clog2(WIDTH) + 1;
    localparam int unsigned MSB = WIDTH - 1;
    localparam logic        MUL_ON = (MUL_EN != 0);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [WIDTH:0]    sum;
    logic [WIDTH:0]    diff;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_c;
    logic              alu_v;
    logic              slt;

    logic [WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]  mplier;
    logic [WIDTH-1:0]  acc;
    logic [CW-1:0]     cnt;

    logic              accept;
    logic              start_mul;
    logic              load_alu;
    logic              finish_mul;
    logic              drop_valid;

    // Single-cycle datapath; the extra top bit of sum/diff is carry-out / borrow.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign slt  = ($signed(a) < $signed(b));

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = ~diff[WIDTH];
                alu_v   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_AND:  alu_res = a & b;
            OP_XOR:  alu_res = a ^ b;
            OP_OR:   alu_res = a | b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
            OP_SHL:  alu_res = a << b[SHW-1:0];
            OP_MUL:  alu_res = '0;
            default: alu_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake control
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        start_mul  = 1'b0;
        load_alu   = 1'b0;
        finish_mul = 1'b0;
        drop_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !out_valid || out_ready;
                accept   = in_valid && in_ready;
                if (accept && MUL_ON && (ALUControl == OP_MUL)) begin
                    start_mul = 1'b1;
                    state_nxt = MUL;
                end else if (accept) begin
                    load_alu = 1'b1;
                end
                drop_valid = out_valid && out_ready && !load_alu;
            end
            MUL: begin
                if (cnt == CW'(WIDTH)) begin
                    finish_mul = 1'b1;
                    state_nxt  = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    drop_valid = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == MUL);

    // Result and flag registers; held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
        end else if (load_alu) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            zero      <= (alu_res == '0);
            carry     <= alu_c;
            overflow  <= alu_v;
        end else if (finish_mul) begin
            out_valid <= 1'b1;
            result    <= acc;
            zero      <= (acc == '0);
            carry     <= 1'b0;
            overflow  <= 1'b0;
        end else if (drop_valid) begin
            out_valid <= 1'b0;
        end
    end

    // Shift-add multiplier: one partial product per cycle, bits above WIDTH dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (start_mul) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if ((state == MUL) && !finish_mul) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Randomized + directed bench for alu_mc (WIDTH=32, MUL_EN=1) against an arithmetic reference model.
module tb_alu_mc;

    localparam int unsigned W = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [2:0]    alu_ctl;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          zero;
    logic          carry;
    logic          overflow;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    alu_mc #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (op_a),
        .b          (op_b),
        .ALUControl (alu_ctl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .carry      (carry),
        .overflow   (overflow),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {overflow, carry, zero, result} from plain integer arithmetic
    function automatic logic [34:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint      sx = longint'($signed(x));
        longint      sy = longint'($signed(y));
        longint      s;
        logic [63:0] wide;
        logic [31:0] r = '0;
        logic        c = 1'b0;
        logic        v = 1'b0;
        case (op)
            3'd0: begin
                wide = 64'(x) + 64'(y);
                r = wide[31:0];
                c = (wide > 64'hFFFF_FFFF);
                s = sx + sy;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                r = x - y;
                c = (x >= y);
                s = sx - sy;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: r = x & y;
            3'd3: r = x ^ y;
            3'd4: r = x | y;
            3'd5: r = (sx < sy) ? 32'd1 : 32'd0;
            3'd6: r = x << (y % 32);
            default: begin
                wide = 64'(x) * 64'(y);
                r = wide[31:0];
            end
        endcase
        return {v, c, (r == 32'd0), r};
    endfunction

    // Present a request and return #1 after the accept edge
    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        int w = 0;
        in_valid = 1'b1;
        alu_ctl  = op;
        op_a     = x;
        op_b     = y;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 200) check("issue_timeout", 64'(w), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Full transaction: accept, wait for result, check, optional stall, consume
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [34:0] exp, input int hold);
        int lat = 0;
        int busy_cnt = 0;
        int rdy_cnt = 0;
        int unstable = 0;
        logic [31:0] r0;
        out_ready = (hold == 0);
        issue(op, x, y);
        while (!out_valid && lat < 200) begin
            // Junk request while busy must be ignored
            in_valid = 1'b1;
            alu_ctl  = 3'b000;
            op_a     = $urandom;
            op_b     = $urandom;
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cnt++;
            if (in_ready) rdy_cnt++;
        end
        in_valid = 1'b0;
        check($sformatf("%s.lat", tag), 64'(lat), (op == 3'b111) ? 64'd33 : 64'd0);
        if (op == 3'b111) begin
            check($sformatf("%s.busy_cycles", tag), 64'(busy_cnt), 64'd32);
            check($sformatf("%s.in_ready_busy", tag), 64'(rdy_cnt), 64'd0);
        end
        check($sformatf("%s.res", tag), 64'(result), 64'(exp[31:0]));
        check($sformatf("%s.flags", tag), {61'd0, overflow, carry, zero}, {61'd0, exp[34:32]});
        r0 = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!out_valid || result !== r0 || in_ready || {overflow, carry, zero} !== exp[34:32]) unstable++;
        end
        if (hold > 0) check($sformatf("%s.stall", tag), 64'(unstable), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check($sformatf("%s.consumed", tag), 64'(out_valid), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int bad;
        logic [2:0]  rop;
        logic [31:0] rx;
        logic [31:0] ry;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_ctl   = 3'b000;
        op_a      = '0;
        op_b      = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst.state", {59'd0, out_valid, busy, zero, carry, overflow}, 64'd0);
        check("rst.result", 64'(result), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst.in_ready", 64'(in_ready), 64'd1);

        // Directed cases from the known-answer list
        run_op("add12_8",   3'd0, 32'd12, 32'd8, {3'b000, 32'd20}, 0);
        run_op("sub20_5",   3'd1, 32'd20, 32'd5, {3'b010, 32'd15}, 0);
        run_op("sub5_5",    3'd1, 32'd5,  32'd5, {3'b011, 32'd0},  0);
        run_op("add_ovf",   3'd0, 32'h7FFF_FFFF, 32'd1, {3'b100, 32'h8000_0000}, 0);
        run_op("add_wrap",  3'd0, 32'hFFFF_FFFF, 32'd1, {3'b011, 32'd0}, 0);
        run_op("xor",       3'd3, 32'hAAAA_5555, 32'h1234_5678, {3'b000, 32'hB89E_032D}, 0);
        run_op("and_zero",  3'd2, 32'hF0F0_F0F0, 32'h0F0F_0F0F, {3'b001, 32'd0}, 0);
        run_op("slt_neg",   3'd5, 32'hFFFF_FFFF, 32'd1,  {3'b000, 32'd1}, 0);
        run_op("slt_5_10",  3'd5, 32'd5,  32'd10, {3'b000, 32'd1}, 0);
        run_op("slt_10_5",  3'd5, 32'd10, 32'd5,  {3'b001, 32'd0}, 0);
        run_op("shl_mask",  3'd6, 32'd1,  32'h25,  {3'b000, 32'h20}, 0);
        run_op("mul7_6",    3'd7, 32'd7,  32'd6,   {3'b000, 32'd42}, 0);
        run_op("mul_wrap",  3'd7, 32'h1_0000, 32'h1_0000, {3'b001, 32'd0}, 0);

        // Backpressure, then swap in a new op on the release edge
        out_ready = 1'b0;
        issue(3'd0, 32'd1, 32'd1);
        check("bp.first", 64'(result), 64'd2);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (result !== 32'd2 || !out_valid || in_ready) bad++;
        end
        check("bp.stable", 64'(bad), 64'd0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        alu_ctl   = 3'd1;
        op_a      = 32'd9;
        op_b      = 32'd4;
        #1;
        check("bp.in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp.no_gap", 64'(out_valid), 64'd1);
        check("bp.second", 64'(result), 64'd5);
        @(posedge clk); #1;
        check("bp.drained", 64'(out_valid), 64'd0);

        // Reset mid-multiply must abort with nothing presented
        issue(3'd7, 32'd3, 32'd3);
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("rstmul.cleared", {61'd0, out_valid, busy, zero}, 64'd0);
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid || result == 32'd9 || busy) bad++;
        end
        check("rstmul.no_result", 64'(bad), 64'd0);
        check("rstmul.result0", 64'(result), 64'd0);
        run_op("post_rst_add", 3'd0, 32'd2, 32'd2, {3'b000, 32'd4}, 0);

        // Randomized ops with random consumer stalls
        for (int n = 0; n < 60; n++) begin
            rop = 3'($urandom_range(0, 7));
            rx  = pick();
            ry  = pick();
            run_op($sformatf("rnd%0d_op%0d", n, rop), rop, rx, ry, model(rop, rx, ry), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
